pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Generates the per-stage stall vector consumed by pc_reg and the stage registers (if_id, id_ex, ex_mem, mem_wb), and the flush pulse that clears them.
- Tracks multi-cycle EX operations with a down-counter.
- Times out hung data-memory handshakes.
- Redirects fetch on exception/ERET.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_mem_timeout_ctr.sv | 32 +++
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall vectors, sequencer states, redirect defaults.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_BASE_DEF = 32'h0000_0020;
    localparam logic [31:0] ZERO_WORD    = '0;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_MC_BUSY = 2'd1,
        PC_FLUSH   = 2'd2
    } pc_state_e;

    function automatic logic [31:0] redirect_target(input logic        is_eret,
                                                    input logic [31:0] epc,
                                                    input logic [31:0] base);
        return is_eret ? epc : base;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mem_timeout_ctr.sv
// Data-memory handshake watchdog: counts unacknowledged wait cycles, pulses bus_err on expiry.
module mem_timeout_ctr
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_wait,
    output logic bus_err
);

    localparam int unsigned    CW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] to_cnt;

    // Restarting from zero on expiry keeps the count bounded and re-arms the next pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= mem_wait && (to_cnt == TO_LAST);
            if (!mem_wait || to_cnt == TO_LAST)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, flush/redirect on exception, multi-cycle EX tracking.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LEN_W    = 6,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] EXC_BASE    = EXC_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                mc_start,
    input  logic [MC_LEN_W-1:0] mc_len,
    input  logic                mem_req,
    input  logic                mem_ack,
    input  logic                excp_valid,
    input  logic                excp_is_eret,
    input  logic [31:0]         epc_i,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                bus_err,
    output logic                mc_busy
);

    pc_state_e           state;
    logic [MC_LEN_W-1:0] mc_cnt;
    logic                excp_take;
    logic                mem_wait;

    // The FLUSH shadow belongs to squashed instructions, so neither exceptions nor mem waits count there.
    assign excp_take = excp_valid && (state != PC_FLUSH);
    assign mem_wait  = mem_req && !mem_ack && (state != PC_FLUSH) && !excp_take;

    always_comb begin
        stall = STALL_NONE;
        if (excp_take || state == PC_FLUSH)
            stall = STALL_NONE;
        else if (mem_wait)
            stall = STALL_MEM;
        else if (state == PC_MC_BUSY)
            stall = STALL_EX;
        else if (stallreq_id)
            stall = STALL_ID;
    end

    assign flush   = excp_take;
    assign new_pc  = excp_take ? redirect_target(excp_is_eret, epc_i, EXC_BASE) : ZERO_WORD;
    assign mc_busy = (state == PC_MC_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PC_RUN;
            mc_cnt <= '0;
        end else begin
            case (state)
                PC_RUN: begin
                    if (excp_take) begin
                        state  <= PC_FLUSH;
                        mc_cnt <= '0;
                    end else if (mc_start && mc_len != '0) begin
                        state  <= PC_MC_BUSY;
                        mc_cnt <= mc_len;
                    end
                end
                PC_MC_BUSY: begin
                    if (excp_take) begin
                        state  <= PC_FLUSH;
                        mc_cnt <= '0;
                    end else if (!mem_wait) begin
                        if (mc_cnt <= MC_LEN_W'(1)) begin
                            state  <= PC_RUN;
                            mc_cnt <= '0;
                        end else begin
                            mc_cnt <= mc_cnt - 1'b1;
                        end
                    end
                end
                PC_FLUSH: state <= PC_RUN;
                default: begin
                    state  <= PC_RUN;
                    mc_cnt <= '0;
                end
            endcase
        end
    end

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .mem_wait(mem_wait),
        .bus_err (bus_err)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed plan items plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, mc_start, mem_req, mem_ack, excp_valid, excp_is_eret;
    logic [5:0]  mc_len;
    logic [31:0] epc_i;
    logic [5:0]  stall;
    logic        flush, bus_err, mc_busy;
    logic [31:0] new_pc;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(
        .MC_LEN_W   (6),
        .MEM_TIMEOUT(TO),
        .EXC_BASE   (32'h0000_0020)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .mc_start    (mc_start),
        .mc_len      (mc_len),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .excp_valid  (excp_valid),
        .excp_is_eret(excp_is_eret),
        .epc_i       (epc_i),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .bus_err     (bus_err),
        .mc_busy     (mc_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles, shadow flag, consecutive wait cycles, pending error pulse.
    int m_busy_left = 0;
    bit m_shadow    = 0;
    int m_wait_run  = 0;
    bit m_berr      = 0;

    function automatic bit m_exc();
        return excp_valid && !m_shadow;
    endfunction

    function automatic bit m_waiting();
        return mem_req && !mem_ack && !m_shadow && !m_exc();
    endfunction

    function automatic logic [5:0] m_stall();
        if (m_exc() || m_shadow) return 6'd0;
        if (m_waiting())         return 6'b011111;
        if (m_busy_left > 0)     return 6'b001111;
        if (stallreq_id)         return 6'b000111;
        return 6'd0;
    endfunction

    function automatic logic [31:0] m_new_pc();
        if (!m_exc()) return 32'h0;
        return excp_is_eret ? epc_i : 32'h0000_0020;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left = 0; m_shadow = 0; m_wait_run = 0; m_berr = 0;
        end else if (m_shadow) begin
            m_shadow = 0; m_wait_run = 0; m_berr = 0;
        end else if (m_exc()) begin
            m_shadow = 1; m_busy_left = 0; m_wait_run = 0; m_berr = 0;
        end else begin
            bit w;
            w = m_waiting();
            m_berr = w && (m_wait_run == TO - 1);
            m_wait_run = (!w || m_wait_run == TO - 1) ? 0 : m_wait_run + 1;
            if (m_busy_left > 0) begin
                if (!w) m_busy_left = m_busy_left - 1;
            end else if (mc_start && mc_len != 0) begin
                m_busy_left = int'(mc_len);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("stall",   32'(stall),   32'(m_stall()));
            chk("flush",   32'(flush),   32'(m_exc()));
            chk("new_pc",  new_pc,       m_new_pc());
            chk("bus_err", 32'(bus_err), 32'(m_berr));
            chk("mc_busy", 32'(mc_busy), 32'(m_busy_left > 0));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stallreq_id = 0; mc_start = 0; mc_len = 0; mem_req = 0; mem_ack = 0;
        excp_valid = 0; excp_is_eret = 0; epc_i = 0;
    endtask

    initial begin
        int pulses;
        int seg_ack;
        int seg_req;
        rst = 1; stallreq_id = 1; mc_start = 1; mc_len = '1; mem_req = 1; mem_ack = 1;
        excp_valid = 1; excp_is_eret = 1; epc_i = '1;
        step(2);
        rst = 0; idle();
        @(negedge clk); #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_newpc", new_pc, 0);
        chk("rst_berr",  32'(bus_err), 0);
        chk("rst_busy",  32'(mc_busy), 0);
        step();

        // load-use hazard for two cycles
        stallreq_id = 1;
        @(negedge clk); #1; chk("id_stall0", 32'(stall), 32'h07);
        step();
        @(negedge clk); #1; chk("id_stall1", 32'(stall), 32'h07);
        step(); stallreq_id = 0;
        @(negedge clk); #1; chk("id_release", 32'(stall), 0);
        step();

        // multi-cycle op of 4, with an ignored second start
        mc_start = 1; mc_len = 4;
        step(); mc_start = 0;
        step(); mc_start = 1; mc_len = 9;
        step(); mc_start = 0;
        step();
        @(negedge clk); #1;
        chk("mc_last_busy",  32'(mc_busy), 1);
        chk("mc_last_stall", 32'(stall),   32'h0f);
        step();
        @(negedge clk); #1;
        chk("mc_done_busy",  32'(mc_busy), 0);
        chk("mc_done_stall", 32'(stall),   0);
        step(2);

        // unacknowledged access: pulses at wait cycles 9 and 17
        mem_req = 1; pulses = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk); #1;
            if (bus_err) begin
                pulses++;
                chk("berr_cycle", i, (i <= 9) ? 9 : 17);
            end
            step();
        end
        chk("berr_pulses", pulses, 2);
        mem_req = 0; step(2);

        // acknowledged at cycle 5: no error
        mem_req = 1; pulses = 0;
        step(4); mem_ack = 1;
        step(); mem_req = 0; mem_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus_err) pulses++;
            step();
        end
        chk("ack_no_berr", pulses, 0);

        // exception during MC_BUSY with mc_cnt=3, then ignored excp in shadow
        mc_start = 1; mc_len = 5;
        step(); mc_start = 0;
        step(2); excp_valid = 1;
        @(negedge clk); #1;
        chk("exc_flush", 32'(flush), 1);
        chk("exc_newpc", new_pc, 32'h20);
        chk("exc_stall", 32'(stall), 0);
        step();
        @(negedge clk); #1;
        chk("shadow_flush", 32'(flush), 0);
        chk("shadow_stall", 32'(stall), 0);
        step(); excp_valid = 0;
        @(negedge clk); #1;
        chk("post_busy", 32'(mc_busy), 0);
        step();

        // ERET with coincident hazard and memory wait
        excp_valid = 1; excp_is_eret = 1; epc_i = 32'h0000_1234; stallreq_id = 1; mem_req = 1;
        @(negedge clk); #1;
        chk("eret_flush", 32'(flush), 1);
        chk("eret_newpc", new_pc, 32'h1234);
        chk("eret_stall", 32'(stall), 0);
        step(); idle(); step(2);

        // randomized traffic, segmented so long memory waits occur
        seg_ack = 0; seg_req = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                seg_ack = int'($urandom_range(0, 3));
                seg_req = int'($urandom_range(0, 2));
            end
            rst          = ($urandom_range(0, 299) == 0);
            stallreq_id  = $urandom_range(0, 3) == 0;
            mc_start     = $urandom_range(0, 7) == 0;
            mc_len       = ($urandom_range(0, 9) == 0) ? 6'(63) : 6'($urandom_range(0, 7));
            mem_req      = (seg_req != 0) && ($urandom_range(0, 3) != 0);
            mem_ack      = (seg_ack != 0) && ($urandom_range(0, 3) == 0);
            excp_valid   = $urandom_range(0, 59) == 0;
            excp_is_eret = $urandom_range(0, 1) == 1;
            epc_i        = $urandom;
            step();
        end
        idle(); rst = 0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
